// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV control unit: opcodes, FSM states
// and the ALU operand/operation select codes driven onto the datapath.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_I_EXEC,
        S_ALU_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the instruction register / memory handshake and the
// multicycle datapath mux selects and enables.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal;
    logic             bus_error;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
               mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal, bus_error, instr_done, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
               mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal, bus_error, instr_done, instr_count
    );
endinterface

// File: rtl/ctrl_mem_wait_timer.sv
// Counts consecutive cycles spent waiting for mem_ready and flags a timeout
// once MEM_TIMEOUT waiting cycles have elapsed with memory still busy.
module ctrl_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    // Leaving a wait state or completing a transfer restarts the count, so
    // every entry into a wait state begins from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!waiting || mem_ready || timeout) begin
            count <= '0;
        end else if (MEM_TIMEOUT > 0) begin
            count <= count + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign timeout = waiting && !mem_ready && (count == CW'(MEM_TIMEOUT));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing each RV instruction through fetch/decode/execute/
// memory/writeback on a shared ALU and memory port, with trap and timeout.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter bit IMM_EN          = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int MEM_TIMEOUT     = 16,
    parameter int CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t           state;
    state_t           next_state;
    state_t           illegal_next;
    logic             legal_op;
    logic             waiting;
    logic             timeout;
    logic             done;
    logic             bus_err_q;
    logic [CNT_W-1:0] count_q;

    assign waiting      = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign illegal_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    ctrl_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting),
        .mem_ready(bus.mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        legal_op = 1'b0;
        case (bus.opcode)
            OP_LOAD, OP_STORE, OP_R, OP_BRANCH: legal_op = 1'b1;
            OP_IMM:                             legal_op = IMM_EN;
            default:                            legal_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready)  next_state = S_DECODE;
                else if (timeout)   next_state = S_TRAP;
            end
            S_DECODE: begin
                if (!legal_op) begin
                    next_state = illegal_next;
                end else begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                        OP_R:              next_state = S_R_EXEC;
                        OP_IMM:            next_state = S_I_EXEC;
                        default:           next_state = S_BRANCH;
                    endcase
                end
            end
            S_MEM_ADDR:  next_state = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (bus.mem_ready)  next_state = S_MEM_WB;
                else if (timeout)   next_state = S_TRAP;
            end
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.mem_ready)  next_state = S_FETCH;
                else if (timeout)   next_state = S_TRAP;
            end
            S_R_EXEC:    next_state = S_ALU_WB;
            S_I_EXEC:    next_state = S_ALU_WB;
            S_ALU_WB:    next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_TRAP:      next_state = S_TRAP;
            default:     next_state = S_FETCH;
        endcase
    end

    // Every output is forced low while reset is held, even though the state
    // register already sits in FETCH.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = ALU_SRC_B_RS2;
        bus.alu_op        = ALU_OP_ADD;
        bus.illegal       = 1'b0;
        bus.bus_error     = 1'b0;
        done              = 1'b0;
        if (!reset) begin
            bus.bus_error = bus_err_q;
            case (state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = ALU_SRC_B_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b = ALU_SRC_B_IMM;
                    done          = !legal_op && !TRAP_ON_ILLEGAL;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALU_SRC_B_IMM;
                end
                S_MEM_READ: begin
                    bus.iord     = 1'b1;
                    bus.mem_read = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    done           = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                    done          = bus.mem_ready;
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALU_SRC_B_RS2;
                    bus.alu_op    = ALU_OP_R;
                end
                S_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALU_SRC_B_IMM;
                    bus.alu_op    = ALU_OP_I;
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                    done          = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_OP_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 1'b1;
                    done              = 1'b1;
                end
                S_TRAP:  bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.instr_done  = done;
    assign bus.instr_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (done)    count_q   <= count_q + 1'b1;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench comparing two configurations of the control FSM against a
// per-instruction cycle-plan model built from the instruction class rules.
module tb_multicycle_control;
    import riscv_ctrl_pkg::*;

    localparam int T_MAIN = 4;

    localparam logic [16:0] PCW     = 17'h10000;
    localparam logic [16:0] PWC     = 17'h08000;
    localparam logic [16:0] PCS     = 17'h04000;
    localparam logic [16:0] IRW     = 17'h02000;
    localparam logic [16:0] IORD    = 17'h01000;
    localparam logic [16:0] MR      = 17'h00800;
    localparam logic [16:0] MW      = 17'h00400;
    localparam logic [16:0] M2R     = 17'h00200;
    localparam logic [16:0] RW      = 17'h00100;
    localparam logic [16:0] SRCA    = 17'h00080;
    localparam logic [16:0] SB_IMM  = 17'h00040;
    localparam logic [16:0] SB_FOUR = 17'h00020;
    localparam logic [16:0] AL_I    = 17'h00018;
    localparam logic [16:0] AL_R    = 17'h00010;
    localparam logic [16:0] AL_SUB  = 17'h00008;
    localparam logic [16:0] ILL     = 17'h00004;
    localparam logic [16:0] BERR    = 17'h00002;
    localparam logic [16:0] DONE    = 17'h00001;

    typedef struct {
        logic [6:0]  op;
        bit          rdy;
        logic [16:0] exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_main;
    logic        rst_nop;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [16:0] obs_main;
    logic [16:0] obs_nop;

    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   cycle_no = 0;
    bit   sel;
    int   cur_tmo;
    bit   cur_trap_ill;
    bit   cur_imm;
    cyc_t plan[$];

    logic [6:0] ops[6] = '{OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, 7'b1111111};

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(32)) mif ();
    multicycle_control_if #(.CNT_W(3))  nif ();

    assign mif.opcode    = opcode;
    assign mif.mem_ready = mem_ready;
    assign nif.opcode    = opcode;
    assign nif.mem_ready = mem_ready;

    multicycle_control #(
        .IMM_EN(1'b1), .TRAP_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(T_MAIN), .CNT_W(32)
    ) dut_main (
        .clk(clk), .reset(rst_main), .bus(mif.master)
    );

    multicycle_control #(
        .IMM_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(0), .CNT_W(3)
    ) dut_nop (
        .clk(clk), .reset(rst_nop), .bus(nif.master)
    );

    assign obs_main = {mif.pc_write, mif.pc_write_cond, mif.pc_source, mif.ir_write, mif.iord,
                       mif.mem_read, mif.mem_write, mif.mem_to_reg, mif.reg_write, mif.alu_src_a,
                       mif.alu_src_b, mif.alu_op, mif.illegal, mif.bus_error, mif.instr_done};
    assign obs_nop  = {nif.pc_write, nif.pc_write_cond, nif.pc_source, nif.ir_write, nif.iord,
                       nif.mem_read, nif.mem_write, nif.mem_to_reg, nif.reg_write, nif.alu_src_a,
                       nif.alu_src_b, nif.alu_op, nif.illegal, nif.bus_error, nif.instr_done};

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic void pushCyc(logic [6:0] op, bit r, logic [16:0] e);
        cyc_t c;
        c.op  = op;
        c.rdy = r;
        c.exp = e;
        plan.push_back(c);
    endfunction

    function automatic void pushTrap(logic [6:0] op, logic [16:0] extra);
        for (int i = 0; i < 5; i++) pushCyc(op, rnd(), ILL | extra);
    endfunction

    // Expected cycle sequence of one instruction; returns 1 if it ends in TRAP.
    // Waiting cycle i (0-based) is tolerated for i < timeout, the next traps.
    function automatic bit buildInstr(logic [6:0] op, int wf, int wm);
        bit legal;
        bit is_load;
        for (int i = 0; i < wf; i++) begin
            pushCyc(op, 1'b0, MR | SB_FOUR);
            if (cur_tmo > 0 && i == cur_tmo) begin
                pushTrap(op, BERR);
                return 1'b1;
            end
        end
        pushCyc(op, 1'b1, MR | SB_FOUR | IRW | PCW);
        legal = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_BRANCH) ||
                (op == OP_IMM && cur_imm);
        if (!legal) begin
            if (cur_trap_ill) begin
                pushCyc(op, rnd(), SB_IMM);
                pushTrap(op, 17'h0);
                return 1'b1;
            end
            pushCyc(op, rnd(), SB_IMM | DONE);
            return 1'b0;
        end
        pushCyc(op, rnd(), SB_IMM);
        if (op == OP_LOAD || op == OP_STORE) begin
            is_load = (op == OP_LOAD);
            pushCyc(op, rnd(), SRCA | SB_IMM);
            for (int i = 0; i < wm; i++) begin
                pushCyc(op, 1'b0, IORD | (is_load ? MR : MW));
                if (cur_tmo > 0 && i == cur_tmo) begin
                    pushTrap(op, BERR);
                    return 1'b1;
                end
            end
            if (is_load) begin
                pushCyc(op, 1'b1, IORD | MR);
                pushCyc(op, rnd(), RW | M2R | DONE);
            end else begin
                pushCyc(op, 1'b1, IORD | MW | DONE);
            end
        end else if (op == OP_R) begin
            pushCyc(op, rnd(), SRCA | AL_R);
            pushCyc(op, rnd(), RW | DONE);
        end else if (op == OP_IMM) begin
            pushCyc(op, rnd(), SRCA | SB_IMM | AL_I);
            pushCyc(op, rnd(), RW | DONE);
        end else begin
            pushCyc(op, rnd(), SRCA | AL_SUB | PWC | PCS | DONE);
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(string tag, logic [16:0] exp);
        logic [16:0] obs;
        logic [31:0] cnt_obs;
        logic [31:0] cnt_exp;
        obs     = sel ? obs_nop : obs_main;
        cnt_obs = sel ? {29'd0, nif.instr_count} : mif.instr_count;
        cnt_exp = sel ? 32'(model_cnt % 8) : 32'(model_cnt);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d outputs got %h expected %h", tag, cycle_no, obs, exp);
        end
        checks++;
        assert (cnt_obs === cnt_exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d instr_count got %0d expected %0d", tag, cycle_no, cnt_obs, cnt_exp);
        end
        if (exp[0]) model_cnt++;
    endtask

    task automatic applyStimulus(string tag, int n);
        cyc_t c;
        int   k;
        k = 0;
        while (plan.size() > 0 && (n < 0 || k < n)) begin
            c         = plan.pop_front();
            opcode    = c.op;
            mem_ready = c.rdy;
            @(negedge clk);
            checkOutput(tag, c.exp);
            @(posedge clk);
            #1;
            cycle_no++;
            k++;
        end
    endtask

    task automatic startDut(bit s);
        sel          = s;
        opcode       = 7'd0;
        mem_ready    = 1'b0;
        rst_main     = 1'b1;
        rst_nop      = 1'b1;
        model_cnt    = 0;
        cur_tmo      = s ? 0 : T_MAIN;
        cur_trap_ill = !s;
        cur_imm      = !s;
        plan.delete();
        @(posedge clk);
        #1;
        checkOutput("reset_state", 17'h0);
        if (s) rst_nop = 1'b0;
        else   rst_main = 1'b0;
    endtask

    initial begin
        logic [6:0] op;
        rst_main  = 1'b1;
        rst_nop   = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b0;

        startDut(1'b0);
        void'(buildInstr(OP_LOAD, 0, 0));
        applyStimulus("load_zero_wait", -1);
        void'(buildInstr(OP_STORE, 0, 3));
        applyStimulus("store_wait3", -1);
        void'(buildInstr(OP_BRANCH, 0, 0));
        void'(buildInstr(OP_R, 0, 0));
        applyStimulus("beq_then_r", -1);
        void'(buildInstr(OP_IMM, 2, 0));
        applyStimulus("itype", -1);
        void'(buildInstr(OP_LOAD, T_MAIN, T_MAIN));
        applyStimulus("wait_at_limit", -1);

        for (int i = 0; i < 150; i++) begin
            void'(buildInstr(ops[$urandom_range(0, 4)], $urandom_range(0, T_MAIN), $urandom_range(0, T_MAIN)));
            applyStimulus("random_main", -1);
        end

        void'(buildInstr(OP_R, T_MAIN + 1, 0));
        applyStimulus("fetch_timeout", -1);

        startDut(1'b0);
        void'(buildInstr(7'b1111111, 0, 0));
        applyStimulus("illegal_trap", -1);

        startDut(1'b0);
        void'(buildInstr(OP_STORE, 0, 0));
        void'(buildInstr(OP_LOAD, 0, 3));
        applyStimulus("pre_reset", 9);
        plan.delete();
        mem_ready = 1'b0;
        #2;
        rst_main  = 1'b1;
        model_cnt = 0;
        #1;
        checkOutput("async_reset", 17'h0);
        @(posedge clk);
        #1;
        rst_main = 1'b0;
        void'(buildInstr(OP_BRANCH, 0, 0));
        applyStimulus("after_reset", -1);

        startDut(1'b1);
        void'(buildInstr(7'b1111111, 0, 0));
        void'(buildInstr(OP_IMM, 0, 0));
        applyStimulus("illegal_nop", -1);
        void'(buildInstr(OP_LOAD, 40, 30));
        applyStimulus("no_timeout", -1);
        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            void'(buildInstr(op, $urandom_range(0, 6), $urandom_range(0, 6)));
            applyStimulus("random_nop", -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder. A Moore FSM sequences each RV instruction through fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds the following over the single-cycle decoder:
  - I-type ALU support
  - memory-ready handshake with timeout
  - illegal-opcode trap
  - retired-instruction counter
- Sits between the instruction register (opcode input) and the multicycle datapath muxes and enables.

Parameters:
- IMM_EN, 1: 1 = decode OP-IMM (0010011); 0 = treat it as illegal.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode parks the FSM in TRAP; 0 = treat it as a NOP and return to FETCH.
- MEM_TIMEOUT, 16: maximum number of cycles to wait for mem_ready; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- ir_write  out  1  latch instruction register
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded R, 11 funct-decoded I
- illegal  out  1  sticky trap flag
- bus_error  out  1  sticky memory timeout flag
- instr_done  out  1  one-cycle pulse per retired instruction
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - asynchronous, active-high, single clock
  - FSM -> FETCH, wait counter = 0, instr_count = 0, illegal = 0, bus_error = 0
  - all outputs forced 0 while reset is high
- Outputs are Moore decodes of state; unlisted outputs are 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00
  - ir_write and pc_write equal mem_ready
  - on mem_ready -> DECODE, else stay
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut)
  - next state by opcode:
    - 0000011 or 0100011 -> MEM_ADDR
    - 0110011 -> R_EXEC
    - 0010011 with IMM_EN -> I_EXEC
    - 1100011 -> BRANCH
    - anything else -> TRAP (TRAP_ON_ILLEGAL=1) or FETCH with instr_done (TRAP_ON_ILLEGAL=0)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; load -> MEM_READ, store -> MEM_WRITE. The opcode is held stable by the IR.
- MEM_READ: iord=1, mem_read=1; on mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WRITE: iord=1, mem_write=1; on mem_ready -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1 -> FETCH.
- TRAP: all enables 0, illegal=1; exit only via reset.
- Latency with zero-wait memory:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Each extra cycle of mem_ready low adds one cycle.
- Wait counter:
  - cleared on entry to FETCH/MEM_READ/MEM_WRITE and whenever mem_ready=1
  - increments each waiting cycle
  - MEM_TIMEOUT>0: if counter reaches MEM_TIMEOUT with mem_ready still low, set bus_error and go to TRAP. Exactly MEM_TIMEOUT waiting cycles are tolerated; the transition happens on the next edge.
- instr_done / instr_count:
  - instr_done pulses in the final cycle of each instruction: MEM_WB, MEM_WRITE with mem_ready, ALU_WB, BRANCH, and illegal-NOP DECODE
  - instr_count increments in the same cycle and wraps modulo 2^CNT_W
  - no increment on a trap or timeout
- Reset mid-instruction: abandons the instruction immediately, with no write or pulse. mem_ready asserted outside a wait state is ignored.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants: OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM
  - state enum typedef
  - ALU_OP_* and ALU_SRC_B_* encodings
- One sub-module, ctrl_mem_wait_timer: counter, clear, and timeout compare, parametrised by MEM_TIMEOUT.

Test Plan:
- Load, mem_ready=1 always, opcode=0000011 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; reg_write=mem_to_reg=1 in cycle 5; instr_count 0->1.
- Store with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held 4 cycles, instr_done on the ready cycle, 7 cycles total, reg_write never 1.
- BEQ then R-type back to back -> pc_write_cond=1, alu_op=01 in cycle 3; R-type alu_op=10 in R_EXEC; instr_count=2 after 7 cycles.
- opcode=1111111 with TRAP_ON_ILLEGAL=1 -> illegal=1 from cycle 3, all enables 0 thereafter, count frozen; with TRAP_ON_ILLEGAL=0 -> back to FETCH, count+1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_error=1 after 4 waiting cycles, FSM in TRAP; with MEM_TIMEOUT=0 -> waits indefinitely.
- Reset asserted in MEM_READ mid-wait -> all outputs 0 asynchronously; after release FETCH, count=0, flags clear.
